// File: rtl/alu_issue.sv
// Issue stage that maps a request onto an external combinational ALU, then
// returns the registered result plus zero/overflow/taken/error flags.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [3:0]  req_tag,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_oper1,
    output logic [31:0] alu_oper2,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_ovf,
    output logic        rsp_taken,
    output logic        rsp_err,
    output logic [3:0]  rsp_tag,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high; a response stays frozen until it is taken.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

    localparam logic [2:0] CLS_NONE = 3'd0;
    localparam logic [2:0] CLS_ADD  = 3'd1;
    localparam logic [2:0] CLS_SUB  = 3'd2;
    localparam logic [2:0] CLS_BEQ  = 3'd3;
    localparam logic [2:0] CLS_JUMP = 3'd4;
    localparam logic [3:0] CTRL_IDLE = 4'hF;

    state_t      state, state_next;
    logic [3:0]  ctrl_q;
    logic [2:0]  cls_q;
    logic [31:0] oper1_q, oper2_q;
    logic [3:0]  tag_q;

    logic [3:0]  map_ctrl;
    logic [2:0]  map_cls;
    logic        map_zero_b;
    logic        map_illegal;
    logic        accept;
    logic        add_ovf, sub_ovf, res_zero;
    logic        ovf_next, taken_next;

    always_comb begin
        map_ctrl    = 4'd0;
        map_cls     = CLS_NONE;
        map_zero_b  = 1'b0;
        map_illegal = 1'b0;
        case (req_op)
            6'd0:                       begin map_ctrl = 4'd0; map_cls = CLS_ADD; end
            6'd1:                       begin map_ctrl = 4'd1; map_cls = CLS_SUB; end
            6'd2:                       map_ctrl = 4'd2;
            6'd3:                       map_ctrl = 4'd3;
            6'd4:                       map_ctrl = 4'd4;
            6'd10, 6'd11, 6'd12, 6'd13: begin map_ctrl = 4'd0; map_cls = CLS_ADD; end
            6'd14:                      begin map_ctrl = 4'd4; map_zero_b = 1'b1; end
            6'd30:                      begin map_ctrl = 4'd1; map_cls = CLS_BEQ; end
            6'd31:                      begin map_ctrl = 4'd0; map_cls = CLS_JUMP; end
            default:                    map_illegal = 1'b1;
        endcase
    end

    assign accept = (state == S_IDLE) && req_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (req_valid) state_next = map_illegal ? S_RESP : S_EXEC;
            S_EXEC:  state_next = S_RESP;
            S_RESP:  if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready   = (state == S_IDLE);
        rsp_valid   = (state == S_RESP);
        alu_control = (state == S_EXEC) ? ctrl_q : CTRL_IDLE;
        dbg_state   = state;
    end

    assign alu_oper1 = oper1_q;
    assign alu_oper2 = oper2_q;

    // Flags are taken from the live ALU result during EXEC against the
    // registered operands, so they match what the ALU actually computed.
    always_comb begin
        res_zero   = (alu_result == 32'd0);
        add_ovf    = (oper1_q[31] == oper2_q[31]) && (alu_result[31] != oper1_q[31]);
        sub_ovf    = (oper1_q[31] != oper2_q[31]) && (alu_result[31] != oper1_q[31]);
        ovf_next   = 1'b0;
        taken_next = 1'b0;
        case (cls_q)
            CLS_ADD:  ovf_next = add_ovf;
            CLS_SUB:  ovf_next = sub_ovf;
            CLS_BEQ:  begin ovf_next = sub_ovf; taken_next = res_zero; end
            CLS_JUMP: begin ovf_next = add_ovf; taken_next = 1'b1; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= CTRL_IDLE;
            cls_q      <= CLS_NONE;
            oper1_q    <= 32'd0;
            oper2_q    <= 32'd0;
            tag_q      <= 4'd0;
            rsp_result <= 32'd0;
            rsp_zero   <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_taken  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_tag    <= 4'd0;
        end else if (accept) begin
            ctrl_q  <= map_ctrl;
            cls_q   <= map_cls;
            oper1_q <= req_a;
            oper2_q <= map_zero_b ? 32'd0 : req_b;
            tag_q   <= req_tag;
            if (map_illegal) begin
                rsp_result <= 32'd0;
                rsp_zero   <= 1'b0;
                rsp_ovf    <= 1'b0;
                rsp_taken  <= 1'b0;
                rsp_err    <= 1'b1;
                rsp_tag    <= req_tag;
            end
        end else if (state == S_EXEC) begin
            rsp_result <= alu_result;
            rsp_zero   <= res_zero;
            rsp_ovf    <= ovf_next;
            rsp_taken  <= taken_next;
            rsp_err    <= 1'b0;
            rsp_tag    <= tag_q;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU attached to its ALU port.
`timescale 1ns/1ps
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_tag;
    logic [3:0]  alu_control;
    logic [31:0] alu_oper1, alu_oper2, alu_result;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_ovf, rsp_taken, rsp_err;
    logic [3:0]  rsp_tag;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, o2, res;
        logic [3:0]  ctrl;
        logic        z, o, t;
    } vec_t;

    alu_issue dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_control(alu_control), .alu_oper1(alu_oper1), .alu_oper2(alu_oper2),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_taken(rsp_taken),
        .rsp_err(rsp_err), .rsp_tag(rsp_tag), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // behavioural ALU; idle code yields a non-zero pattern
    always_comb begin
        case (alu_control)
            4'd0:    alu_result = alu_oper1 + alu_oper2;
            4'd1:    alu_result = alu_oper1 - alu_oper2;
            4'd2:    alu_result = alu_oper1 * alu_oper2;
            4'd3:    alu_result = alu_oper1 & alu_oper2;
            4'd4:    alu_result = alu_oper1 | alu_oper2;
            default: alu_result = 32'hDEADBEEF;
        endcase
    end

    // driver: offer one request, wait for the response, leave it un-taken
    task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, output int lat, output int ctrl_cycles,
                        output logic [3:0] ctrl_seen, output logic [31:0] o1, output logic [31:0] o2);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_op = 6'd1; req_a = 32'hFFFF_FFFF; req_b = 32'h5555_5555; req_tag = ~tag;
        lat = 1; ctrl_cycles = 0; ctrl_seen = 4'hF;
        o1 = alu_oper1; o2 = alu_oper2;
        while (!rsp_valid && lat < 8) begin
            if (alu_control !== 4'hF) begin ctrl_cycles++; ctrl_seen = alu_control; end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 6'd0; req_a = 32'd0; req_b = 32'd0; req_tag = 4'd0;
        repeat (2) @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_vec++; if (alu_control !== 4'hF) begin n_err++; $display("FAIL reset_ctrl got %h want f", alu_control); end
        n_vec++; if ({alu_oper1, alu_oper2} !== 64'd0) begin n_err++; $display("FAIL reset_opers got %h %h want 0", alu_oper1, alu_oper2); end
        n_vec++; if ({rsp_result, rsp_zero, rsp_ovf, rsp_taken, rsp_err, rsp_tag} !== 40'd0) begin
            n_err++; $display("FAIL reset_rsp got %h %b%b%b%b %h want 0", rsp_result, rsp_zero, rsp_ovf, rsp_taken, rsp_err, rsp_tag);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu_ops();
        vec_t tbl[11];
        int lat, cc;
        logic [3:0] cs;
        logic [31:0] o1, o2;
        tbl[0]  = '{6'd0,  32'd5,          32'd7,          32'd7,          32'd12,         4'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{6'd0,  32'h7FFF_FFFF,  32'd1,          32'd1,          32'h8000_0000,  4'd0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{6'd1,  32'h8000_0000,  32'd1,          32'd1,          32'h7FFF_FFFF,  4'd1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{6'd1,  32'd5,          32'd5,          32'd5,          32'd0,          4'd1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{6'd2,  32'h0001_0000,  32'h0001_0001,  32'h0001_0001,  32'h0001_0000,  4'd2, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{6'd3,  32'hF0F0_00FF,  32'h0FF0_F0F0,  32'h0FF0_F0F0,  32'h00F0_00F0,  4'd3, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{6'd4,  32'h1200_0034,  32'h0000_5600,  32'h0000_5600,  32'h1200_5634,  4'd4, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{6'd14, 32'h0000_ABCD,  32'h0000_1234,  32'd0,          32'h0000_ABCD,  4'd4, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{6'd11, 32'h0000_0100,  32'h0000_0024,  32'h0000_0024,  32'h0000_0124,  4'd0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{6'd31, 32'h7FFF_FFF0,  32'h0000_0020,  32'h0000_0020,  32'h8000_0010,  4'd0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{6'd12, 32'hFFFF_FFFF,  32'd1,          32'd1,          32'd0,          4'd0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b, 4'(i), lat, cc, cs, o1, o2);
            n_vec++; if (lat !== 2) begin n_err++; $display("FAIL op%0d_latency got %0d want 2", i, lat); end
            n_vec++; if (cc !== 1 || cs !== tbl[i].ctrl) begin n_err++; $display("FAIL op%0d_ctrl got %h x%0d want %h x1", i, cs, cc, tbl[i].ctrl); end
            n_vec++; if (o1 !== tbl[i].a || o2 !== tbl[i].o2) begin n_err++; $display("FAIL op%0d_opers got %h %h want %h %h", i, o1, o2, tbl[i].a, tbl[i].o2); end
            n_vec++; if (rsp_result !== tbl[i].res) begin n_err++; $display("FAIL op%0d_result got %h want %h", i, rsp_result, tbl[i].res); end
            n_vec++; if ({rsp_zero, rsp_ovf, rsp_taken, rsp_err} !== {tbl[i].z, tbl[i].o, tbl[i].t, 1'b0}) begin
                n_err++; $display("FAIL op%0d_flags zotE got %b%b%b%b want %b%b%b0", i, rsp_zero, rsp_ovf, rsp_taken, rsp_err, tbl[i].z, tbl[i].o, tbl[i].t);
            end
            n_vec++; if (rsp_tag !== 4'(i) || alu_control !== 4'hF || alu_oper1 !== tbl[i].a) begin
                n_err++; $display("FAIL op%0d_resp_state tag %h ctrl %h oper1 %h want %h f %h", i, rsp_tag, alu_control, alu_oper1, 4'(i), tbl[i].a);
            end
            take_rsp();
        end
    endtask

    task automatic test_beq();
        int lat, cc;
        logic [3:0] cs;
        logic [31:0] o1, o2;
        send(6'd30, 32'd9, 32'd9, 4'hA, lat, cc, cs, o1, o2);
        n_vec++; if (lat !== 2 || cs !== 4'd1) begin n_err++; $display("FAIL beq_eq_issue lat %0d ctrl %h want 2 1", lat, cs); end
        n_vec++; if ({rsp_result, rsp_zero, rsp_taken, rsp_ovf} !== {32'd0, 1'b1, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL beq_eq got %h z%b t%b o%b want 0 z1 t1 o0", rsp_result, rsp_zero, rsp_taken, rsp_ovf);
        end
        take_rsp();
        send(6'd30, 32'd9, 32'd8, 4'hB, lat, cc, cs, o1, o2);
        n_vec++; if ({rsp_result, rsp_zero, rsp_taken, rsp_tag} !== {32'd1, 1'b0, 1'b0, 4'hB}) begin
            n_err++; $display("FAIL beq_ne got %h z%b t%b tag %h want 1 z0 t0 b", rsp_result, rsp_zero, rsp_taken, rsp_tag);
        end
        take_rsp();
    endtask

    task automatic test_illegal();
        int lat, cc;
        logic [3:0] cs;
        logic [31:0] o1, o2;
        send(6'd20, 32'd3, 32'd4, 4'h6, lat, cc, cs, o1, o2);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL illegal_latency got %0d want 1", lat); end
        n_vec++; if (cc !== 0 || alu_control !== 4'hF) begin n_err++; $display("FAIL illegal_ctrl got %0d active cycles ctrl %h want 0 f", cc, alu_control); end
        n_vec++; if ({rsp_err, rsp_result, rsp_zero, rsp_ovf, rsp_taken, rsp_tag} !== {1'b1, 32'd0, 3'b000, 4'h6}) begin
            n_err++; $display("FAIL illegal_rsp err %b res %h zot %b%b%b tag %h want 1 0 000 6", rsp_err, rsp_result, rsp_zero, rsp_ovf, rsp_taken, rsp_tag);
        end
        take_rsp();
    endtask

    task automatic test_backpressure();
        int lat, cc;
        logic [3:0] cs;
        logic [31:0] o1, o2;
        send(6'd0, 32'd10, 32'd20, 4'h5, lat, cc, cs, o1, o2);
        req_valid = 1'b1; req_op = 6'd1; req_a = 32'd1; req_b = 32'd1; req_tag = 4'h9;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== 32'd30 || rsp_tag !== 4'h5 || alu_control !== 4'hF) begin
                n_err++; $display("FAIL stall_c%0d v%b rdy%b res %h tag %h ctrl %h want 1 0 1e 5 f", c, rsp_valid, req_ready, rsp_result, rsp_tag, alu_control);
            end
        end
        req_valid = 1'b0;
        take_rsp();
        n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL stall_release v%b rdy%b want 0 1", rsp_valid, req_ready); end
        @(negedge clk);
        n_vec++; if (alu_control !== 4'hF || req_ready !== 1'b1) begin n_err++; $display("FAIL stall_ignored ctrl %h rdy %b want f 1", alu_control, req_ready); end
    endtask

    task automatic test_reset_mid();
        int lat, cc;
        logic [3:0] cs;
        logic [31:0] o1, o2;
        @(negedge clk);
        req_valid = 1'b1; req_op = 6'd2; req_a = 32'd6; req_b = 32'd7; req_tag = 4'h3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_vec++; if (alu_control !== 4'd2) begin n_err++; $display("FAIL mid_exec ctrl got %h want 2", alu_control); end
        rst = 1'b1;
        #1;
        n_vec++; if (alu_control !== 4'hF || rsp_valid !== 1'b0 || {alu_oper1, alu_oper2} !== 64'd0) begin
            n_err++; $display("FAIL mid_reset ctrl %h v%b opers %h %h want f 0 0 0", alu_control, rsp_valid, alu_oper1, alu_oper2);
        end
        n_vec++; if ({rsp_result, rsp_tag, rsp_err} !== 37'd0) begin n_err++; $display("FAIL mid_reset_rsp res %h tag %h err %b want 0", rsp_result, rsp_tag, rsp_err); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_c%0d v%b rdy%b want 0 1", c, rsp_valid, req_ready); end
        end
        send(6'd0, 32'd1, 32'd1, 4'h2, lat, cc, cs, o1, o2);
        n_vec++; if (lat !== 2 || rsp_result !== 32'd2 || rsp_tag !== 4'h2) begin
            n_err++; $display("FAIL post_reset_add lat %0d res %h tag %h want 2 2 2", lat, rsp_result, rsp_tag);
        end
        take_rsp();
    endtask

    task automatic test_back_to_back();
        int seen;
        logic [31:0] exp_r;
        seen = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = 6'd0; req_a = 32'd10; req_b = 32'd100; req_tag = 4'h1;
        exp_q.push_back(32'd110); exp_q.push_back(32'd111); exp_q.push_back(32'd112);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen++;
                exp_r = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hX;
                n_vec++; if (rsp_result !== exp_r) begin n_err++; $display("FAIL b2b_result got %h want %h", rsp_result, exp_r); end
                req_a = req_a + 32'd1;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_vec++; if (seen !== 3) begin n_err++; $display("FAIL b2b_throughput got %0d responses in 9 cycles want 3", seen); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_beq();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Ports SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-002 req_valid  in  1  request offered.
REQ-003 req_ready  out  1  request accepted when high with req_valid at a clk edge.
REQ-004 req_op  in  6  operation code: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 10 LDB, 11 LDW, 12 STB, 13 STW, 14 MOV, 30 BEQ, 31 JUMP.
REQ-005 req_a / req_b  in  32 each  operands.
REQ-006 req_tag  in  4  caller tag, returned unchanged.
REQ-007 alu_control  out  4  control to ALU.
REQ-008 alu_oper1 / alu_oper2  out  32 each  operands to ALU.
REQ-009 alu_result  in  32  ALU result; ALU overflow/zero outputs are not used.
REQ-010 rsp_valid  in/out: out  1  response valid; rsp_ready  in  1  consumer accepts.
REQ-011 rsp_result  out  32; rsp_zero  out  1; rsp_ovf  out  1; rsp_taken  out  1; rsp_err  out  1; rsp_tag  out  4.

Function
REQ-012 FSM states IDLE, EXEC, RESP; encoding free.
REQ-013 IDLE: req_ready=1; on req_valid go to EXEC, registering mapped control, operands, tag, op class.
REQ-014 EXEC lasts exactly one cycle; alu_control = mapped code only in EXEC, 4'hF (idle) in every other state, so every issue produces a control transition at the ALU.
REQ-015 Op mapping: ADD/SUB/MUL/AND/OR -> control 0/1/2/3/4 with oper1=a, oper2=b; LDB/LDW/STB/STW/JUMP -> control 0 (a+b); MOV -> control 4 with oper2=0; BEQ -> control 1 (a-b).
REQ-016 alu_oper1/alu_oper2 SHALL hold the registered operands from the cycle after accept until the next accept.
REQ-017 At the edge ending EXEC: rsp_result <= alu_result; rsp_zero <= (alu_result==0), computed locally; state -> RESP.
REQ-018 rsp_ovf: ADD/mem/JUMP = signed add overflow (sign(a)==sign(b) and sign(result)!=sign(a)); SUB/BEQ = signed sub overflow (sign(a)!=sign(b) and sign(result)!=sign(a)); all other ops 0.
REQ-019 rsp_taken = 1 for BEQ with zero result, 1 for JUMP, else 0.
REQ-020 Any req_op not in REQ-004: skip EXEC, go IDLE->RESP with rsp_err=1, rsp_result=0, rsp_zero=0, rsp_ovf=0, rsp_taken=0, alu_control stays 4'hF.
REQ-021 RESP: rsp_valid=1, req_ready=0; all rsp_* held stable until rsp_valid&&rsp_ready, then -> IDLE.
REQ-022 Latency: accept at edge N -> rsp_valid high from edge N+2 (legal op) or N+1 (illegal op); peak throughput one op per 3 cycles with rsp_ready tied high.
REQ-023 req_* inputs are sampled only on accept; changes while busy SHALL have no effect.
REQ-024 Arithmetic widths: all results modulo 2^32; MUL returns low 32 bits, no overflow flag.

Reset
REQ-025 rst asserted at any time (incl. mid-EXEC or RESP) SHALL immediately force IDLE, req_ready=1 after release, rsp_valid=0, alu_control=4'hF, alu_oper1/2=0, all rsp_* =0; an in-flight op is discarded, no response issued.

Verification
REQ-026 ADD a=5, b=7, rsp_ready=1 -> alu_control 0 for one cycle, rsp_result=12, zero=0, ovf=0, rsp_valid at N+2.
REQ-027 ADD a=32'h7FFFFFFF, b=1 -> rsp_result=32'h80000000, rsp_ovf=1; SUB a=32'h80000000, b=1 -> result 32'h7FFFFFFF, ovf=1.
REQ-028 BEQ a=b=9 -> rsp_result=0, rsp_zero=1, rsp_taken=1; BEQ a=9, b=8 -> taken=0.
REQ-029 req_op=20 -> rsp_err=1 at N+1, alu_control never leaves 4'hF.
REQ-030 rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0, second req_valid ignored until handshake.
REQ-031 rst pulsed during EXEC of MUL -> all outputs reset values, no rsp_valid; next ADD completes normally.
